ch_trigger_stop: RTL and testbench

Per-channel trigger consumer: takes the channel `trigger` (asynchronous to FCLK when TRIG_DELAY is 0) and resynchronises and edge-detects it. After a programmable post-trigger delay it requests a sampling stop from the channel state machine, capturing the sample write address at the trigger and at the stop. It sits between the channel trigger generator and the channel control FSM / readout address logic.

---
 rtl/ch_trigger_stop_pkg.sv | 13 +
 rtl/ch_trigger_stop.sv | 134 +++++++++++++
 tb/tb_ch_trigger_stop.sv | 380 ++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ch_trigger_stop_pkg.sv
// Channel control state encoding shared by the channel FSM and its consumers.
package ch_trigger_stop_pkg;

    typedef enum logic [2:0] {
        STATE_INIT      = 3'd0,
        STATE_STOPPED   = 3'd1,
        STATE_ARMING    = 3'd2,
        STATE_SAMPLING  = 3'd3,
        STATE_TRIGGERED = 3'd4,
        STATE_READOUT   = 3'd5
    } state_t;

endpackage

// File: rtl/ch_trigger_stop.sv
// Per-channel trigger consumer: resynchronises the trigger, waits a post-trigger delay, then requests a stop.
// Optional trigger timestamp counter enabled by defining CH_TRIG_STOP_TIMESTAMP_EN.
module ch_trigger_stop
    import ch_trigger_stop_pkg::*;
#(
    parameter int SAMPLE_ADDR_W = 8,
    parameter int POST_TRIG_W   = 8
) (
    input  logic                     FCLK,
    input  logic                     INST_START,
    input  logic                     trigger,
    input  state_t                   current_state,
    input  logic [POST_TRIG_W-1:0]   POST_TRIG_COUNT,
    input  logic [SAMPLE_ADDR_W-1:0] SAMPLE_ADDR,
    input  logic                     stop_ack,
    output logic                     stop_req,
    output logic                     trig_seen,
    output logic [SAMPLE_ADDR_W-1:0] trig_addr,
    output logic [SAMPLE_ADDR_W-1:0] stop_addr,
    output logic [15:0]              trig_time,
    output logic [2:0]               dbg_state
);

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_ARMED = 3'd1;
    localparam logic [2:0] ST_POST  = 3'd2;
    localparam logic [2:0] ST_STOP  = 3'd3;
    localparam logic [2:0] ST_DONE  = 3'd4;

    logic [2:0]             state;
    logic                   sync1, sync2, sync3;
    logic                   trig_edge;
    logic                   sampling;
    logic [POST_TRIG_W-1:0] count;
    logic [15:0]            ts_now;

    always_ff @(posedge FCLK or posedge INST_START) begin
        if (INST_START) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            sync3 <= 1'b0;
        end else begin
            sync1 <= trigger;
            sync2 <= sync1;
            sync3 <= sync2;
        end
    end

    assign trig_edge = sync2 & ~sync3;
    assign sampling  = (current_state != STATE_STOPPED) &&
                       (current_state != STATE_INIT) &&
                       (current_state != STATE_READOUT);

`ifdef CH_TRIG_STOP_TIMESTAMP_EN
    logic [15:0] ts_cnt;

    always_ff @(posedge FCLK or posedge INST_START) begin
        if (INST_START) ts_cnt <= 16'd0;
        else            ts_cnt <= ts_cnt + 16'd1;
    end

    assign ts_now = ts_cnt;
`else
    assign ts_now = 16'd0;
`endif

    // stop_req is a level held from entry into STOP until stop_ack is sampled high;
    // stop_ack in any other state has no effect.
    assign stop_req  = (state == ST_STOP);
    assign dbg_state = state;

    always_ff @(posedge FCLK or posedge INST_START) begin
        if (INST_START) begin
            state     <= ST_IDLE;
            count     <= '0;
            trig_seen <= 1'b0;
            trig_addr <= '0;
            stop_addr <= '0;
            trig_time <= 16'd0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (sampling) begin
                        state     <= ST_ARMED;
                        count     <= '0;
                        trig_seen <= 1'b0;
                        trig_addr <= '0;
                        stop_addr <= '0;
                        trig_time <= 16'd0;
                    end
                end
                ST_ARMED: begin
                    if (!sampling) begin
                        state <= ST_IDLE;
                        count <= '0;
                    end else if (trig_edge) begin
                        trig_seen <= 1'b1;
                        trig_addr <= SAMPLE_ADDR;
                        trig_time <= ts_now;
                        if (POST_TRIG_COUNT == '0) begin
                            stop_addr <= SAMPLE_ADDR;
                            state     <= ST_STOP;
                        end else begin
                            count <= POST_TRIG_COUNT;
                            state <= ST_POST;
                        end
                    end
                end
                ST_POST: begin
                    if (!sampling) begin
                        state <= ST_IDLE;
                        count <= '0;
                    end else begin
                        // Saturating decrement; the last count of 1 is the stop edge.
                        if (count != '0) count <= count - POST_TRIG_W'(1);
                        if (count <= POST_TRIG_W'(1)) begin
                            stop_addr <= SAMPLE_ADDR;
                            state     <= ST_STOP;
                        end
                    end
                end
                ST_STOP: begin
                    if (stop_ack) state <= ST_DONE;
                end
                ST_DONE: begin
                    if ((current_state == STATE_STOPPED) || (current_state == STATE_INIT))
                        state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ch_trigger_stop.sv
// Bench for ch_trigger_stop: directed vector table, multi-cycle sequences and a random phase
// checked cycle by cycle against a behavioural model.
module tb_ch_trigger_stop;
    import ch_trigger_stop_pkg::*;

    localparam int AW = 8;
    localparam int PW = 8;

    localparam int M_IDLE  = 0;
    localparam int M_ARMED = 1;
    localparam int M_POST  = 2;
    localparam int M_STOP  = 3;
    localparam int M_DONE  = 4;

    logic          FCLK = 1'b0;
    logic          INST_START = 1'b0;
    logic          trigger = 1'b0;
    state_t        current_state = STATE_INIT;
    logic [PW-1:0] post_trig_count = '0;
    logic [AW-1:0] sample_addr = '0;
    logic          stop_ack = 1'b0;
    logic          stop_req;
    logic          trig_seen;
    logic [AW-1:0] trig_addr;
    logic [AW-1:0] stop_addr;
    logic [15:0]   trig_time;
    logic [2:0]    dbg_state;

    int n_checks = 0;
    int n_fail   = 0;

    ch_trigger_stop #(.SAMPLE_ADDR_W(AW), .POST_TRIG_W(PW)) dut (
        .FCLK            (FCLK),
        .INST_START      (INST_START),
        .trigger         (trigger),
        .current_state   (current_state),
        .POST_TRIG_COUNT (post_trig_count),
        .SAMPLE_ADDR     (sample_addr),
        .stop_ack        (stop_ack),
        .stop_req        (stop_req),
        .trig_seen       (trig_seen),
        .trig_addr       (trig_addr),
        .stop_addr       (stop_addr),
        .trig_time       (trig_time),
        .dbg_state       (dbg_state)
    );

    // clock / reset
    always #5 FCLK = ~FCLK;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // behavioural reference model: stop is due at an absolute cycle index
    int          m_mode  = M_IDLE;
    bit          m_seen  = 1'b0;
    logic [7:0]  m_taddr = '0;
    logic [7:0]  m_saddr = '0;
    logic [15:0] m_ttime = '0;
    longint      m_due   = 0;
    longint      m_cyc   = 0;
    bit          samp_q[$] = '{1'b0, 1'b0, 1'b0};
    logic [15:0] exp_q[$];
    bit          m_rise;
    bit          m_smp;
    logic [15:0] m_ts;

    function automatic bit is_sampling(input state_t s);
        return !(s == STATE_STOPPED || s == STATE_INIT || s == STATE_READOUT);
    endfunction

    always @(posedge FCLK or posedge INST_START) begin
        if (INST_START) begin
            m_mode  = M_IDLE;
            m_seen  = 1'b0;
            m_taddr = '0;
            m_saddr = '0;
            m_ttime = '0;
            m_due   = 0;
            m_cyc   = 0;
            samp_q  = '{1'b0, 1'b0, 1'b0};
        end else begin
            m_rise = samp_q[1] && !samp_q[0];
            m_smp  = is_sampling(current_state);
`ifdef CH_TRIG_STOP_TIMESTAMP_EN
            m_ts = m_cyc[15:0];
`else
            m_ts = 16'd0;
`endif
            case (m_mode)
                M_IDLE: if (m_smp) begin
                    m_mode = M_ARMED; m_seen = 1'b0;
                    m_taddr = '0; m_saddr = '0; m_ttime = '0;
                end
                M_ARMED: if (!m_smp) m_mode = M_IDLE;
                else if (m_rise) begin
                    m_seen = 1'b1; m_taddr = sample_addr; m_ttime = m_ts;
                    if (post_trig_count == 0) begin
                        m_saddr = sample_addr; m_mode = M_STOP;
                        exp_q.push_back({m_taddr, m_saddr});
                    end else begin
                        m_due = m_cyc + longint'(post_trig_count); m_mode = M_POST;
                    end
                end
                M_POST: if (!m_smp) m_mode = M_IDLE;
                else if (m_cyc == m_due) begin
                    m_saddr = sample_addr; m_mode = M_STOP;
                    exp_q.push_back({m_taddr, m_saddr});
                end
                M_STOP: if (stop_ack) m_mode = M_DONE;
                M_DONE: if (current_state == STATE_STOPPED || current_state == STATE_INIT) m_mode = M_IDLE;
                default: m_mode = M_IDLE;
            endcase
            samp_q.push_back(trigger);
            void'(samp_q.pop_front());
            m_cyc++;
        end
    end

    // scoreboard: every cycle against the model, plus address pairs at each stop_req rise
    bit prev_req = 1'b0;
    logic [15:0] sb_exp;

    always @(negedge FCLK) begin
        check("m_stop_req",  32'(stop_req),  32'(m_mode == M_STOP));
        check("m_state",     32'(dbg_state), 32'(m_mode));
        check("m_trig_seen", 32'(trig_seen), 32'(m_seen));
        check("m_trig_addr", 32'(trig_addr), 32'(m_taddr));
        check("m_stop_addr", 32'(stop_addr), 32'(m_saddr));
        check("m_trig_time", 32'(trig_time), 32'(m_ttime));
        if (stop_req && !prev_req) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL sb_unexpected_stop: stop_req rose with no expected stop at %0t", $time);
            end else begin
                sb_exp = exp_q.pop_front();
                check("sb_addrs", 32'({trig_addr, stop_addr}), 32'(sb_exp));
            end
        end
        prev_req = stop_req;
    end

    // driver tasks
    task automatic tick(input int n);
        repeat (n) @(negedge FCLK);
    endtask

    task automatic go_idle();
        current_state = STATE_INIT;
        trigger = 1'b0;
        stop_ack = 1'b1;
        tick(3);
        stop_ack = 1'b0;
        tick(1);
    endtask

    task automatic arm();
        current_state = STATE_SAMPLING;
        trigger = 1'b0;
        tick(4);
    endtask

    task automatic pulse_trig();
        trigger = 1'b1;
        tick(2);
        trigger = 1'b0;
    endtask

    task automatic wait_req(input int bound, output bit ok);
        ok = 1'b0;
        for (int k = 0; k < bound; k++) begin
            @(negedge FCLK);
            if (stop_req) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    typedef struct {
        logic [7:0] p;
        logic [7:0] a0;
        int         lat;
        logic [7:0] taddr;
        logic [7:0] saddr;
    } vec_t;

    vec_t vecs[5];

    initial begin
        #5_000_000;
        n_fail++;
        $display("FAIL timeout: simulation time limit reached");
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        bit ok;
        int lat;
        bit seen_req;

        vecs[0] = '{p: 8'd0,   a0: 8'h33, lat: 2,   taddr: 8'h35, saddr: 8'h35};
        vecs[1] = '{p: 8'd5,   a0: 8'h10, lat: 7,   taddr: 8'h12, saddr: 8'h17};
        vecs[2] = '{p: 8'd1,   a0: 8'hFE, lat: 3,   taddr: 8'h00, saddr: 8'h01};
        vecs[3] = '{p: 8'd255, a0: 8'h80, lat: 257, taddr: 8'h82, saddr: 8'h81};
        vecs[4] = '{p: 8'd2,   a0: 8'h00, lat: 4,   taddr: 8'h02, saddr: 8'h04};

        // reset
        #1 INST_START = 1'b1;
        #1;
        check("rst_stop_req",  32'(stop_req),  32'd0);
        check("rst_trig_seen", 32'(trig_seen), 32'd0);
        check("rst_trig_addr", 32'(trig_addr), 32'd0);
        check("rst_stop_addr", 32'(stop_addr), 32'd0);
        check("rst_trig_time", 32'(trig_time), 32'd0);
        check("rst_state",     32'(dbg_state), 32'd0);
        tick(2);
        INST_START = 1'b0;
        tick(2);

        // vector table: trigger pulse with incrementing address, extra pulse during POST
        for (int i = 0; i < 5; i++) begin
            go_idle();
            arm();
            post_trig_count = vecs[i].p;
            sample_addr = vecs[i].a0;
            trigger = 1'b1;
            lat = -1;
            for (int k = 0; k < 300 && lat < 0; k++) begin
                @(negedge FCLK);
                if (stop_req) lat = k;
                sample_addr = sample_addr + 8'd1;
                if (k == 1) trigger = 1'b0;
                if (k == 4) trigger = 1'b1;
                if (k == 5) trigger = 1'b0;
            end
            trigger = 1'b0;
            check($sformatf("vec%0d_latency", i), 32'(lat), 32'(vecs[i].lat));
            check($sformatf("vec%0d_trig_addr", i), 32'(trig_addr), 32'(vecs[i].taddr));
            check($sformatf("vec%0d_stop_addr", i), 32'(stop_addr), 32'(vecs[i].saddr));
            check($sformatf("vec%0d_trig_seen", i), 32'(trig_seen), 32'd1);
        end

        // stop_ack held low, then one-cycle ack, readout hold, clear on re-entry
        go_idle();
        arm();
        post_trig_count = 8'd3;
        sample_addr = 8'h40;
        pulse_trig();
        wait_req(20, ok);
        check("ack_wait_req", 32'(ok), 32'd1);
        for (int k = 0; k < 20; k++) begin
            @(negedge FCLK);
            check("ack_hold_req", 32'(stop_req), 32'd1);
        end
        stop_ack = 1'b1;
        tick(1);
        stop_ack = 1'b0;
        check("ack_req_low",  32'(stop_req),  32'd0);
        check("ack_done",     32'(dbg_state), 32'(M_DONE));
        current_state = STATE_READOUT;
        tick(5);
        check("readout_state", 32'(dbg_state), 32'(M_DONE));
        check("readout_seen",  32'(trig_seen), 32'd1);
        check("readout_taddr", 32'(trig_addr), 32'h40);
        check("readout_saddr", 32'(stop_addr), 32'h40);
        current_state = STATE_INIT;
        tick(2);
        check("init_idle", 32'(dbg_state), 32'(M_IDLE));
        check("init_seen", 32'(trig_seen), 32'd1);
        current_state = STATE_SAMPLING;
        tick(1);
        check("rearm_state", 32'(dbg_state), 32'(M_ARMED));
        check("rearm_seen",  32'(trig_seen), 32'd0);
        check("rearm_taddr", 32'(trig_addr), 32'd0);
        check("rearm_saddr", 32'(stop_addr), 32'd0);

        // abort during a long post-trigger delay
        go_idle();
        arm();
        post_trig_count = 8'd200;
        sample_addr = 8'h22;
        pulse_trig();
        tick(48);
        current_state = STATE_STOPPED;
        tick(1);
        check("abort_idle",  32'(dbg_state), 32'(M_IDLE));
        check("abort_seen",  32'(trig_seen), 32'd1);
        check("abort_taddr", 32'(trig_addr), 32'h22);
        seen_req = 1'b0;
        for (int k = 0; k < 250; k++) begin
            @(negedge FCLK);
            if (stop_req) seen_req = 1'b1;
        end
        check("abort_no_req", 32'(seen_req), 32'd0);

        // async reset while in STOP, then trigger held high across re-arm
        go_idle();
        arm();
        post_trig_count = 8'd0;
        sample_addr = 8'h5A;
        trigger = 1'b1;
        wait_req(10, ok);
        check("rst_stop_wait", 32'(ok), 32'd1);
        current_state = STATE_STOPPED;
        #3 INST_START = 1'b1;
        #1;
        check("arst_stop_req",  32'(stop_req),  32'd0);
        check("arst_trig_seen", 32'(trig_seen), 32'd0);
        check("arst_trig_addr", 32'(trig_addr), 32'd0);
        check("arst_stop_addr", 32'(stop_addr), 32'd0);
        check("arst_state",     32'(dbg_state), 32'(M_IDLE));
        tick(1);
        INST_START = 1'b0;
        tick(5);
        current_state = STATE_SAMPLING;
        tick(10);
        check("held_no_fire_seen", 32'(trig_seen), 32'd0);
        check("held_no_fire_req",  32'(stop_req),  32'd0);
        trigger = 1'b0;
        tick(3);
        trigger = 1'b1;
        tick(4);
        check("refire_seen", 32'(trig_seen), 32'd1);
        check("refire_req",  32'(stop_req),  32'd1);
        check("refire_addr", 32'(stop_addr), 32'h5A);
`ifndef CH_TRIG_STOP_TIMESTAMP_EN
        check("trig_time_off", 32'(trig_time), 32'd0);
`endif
        trigger = 1'b0;

        // random phase against the model
        go_idle();
        for (int k = 0; k < 3000; k++) begin
            @(negedge FCLK);
            if ($urandom_range(0, 19) == 0) current_state = state_t'(3'($urandom_range(0, 5)));
            if ($urandom_range(0, 5) == 0) trigger = ~trigger;
            stop_ack = ($urandom_range(0, 3) == 0);
            post_trig_count = 8'($urandom_range(0, 12));
            sample_addr = 8'($urandom);
            if ($urandom_range(0, 599) == 0) begin
                #1 INST_START = 1'b1;
                #2 INST_START = 1'b0;
            end
        end
        stop_ack = 1'b0;
        trigger = 1'b0;

`ifdef CH_TRIG_STOP_TIMESTAMP_EN
        // timestamp wraps: capture at cycle index 70000
        INST_START = 1'b1;
        current_state = STATE_SAMPLING;
        trigger = 1'b0;
        post_trig_count = 8'd0;
        #2;
        @(negedge FCLK);
        INST_START = 1'b0;
        tick(69998);
        trigger = 1'b1;
        tick(3);
        check("ts_seen", 32'(trig_seen), 32'd1);
        check("ts_wrap", 32'(trig_time), 32'd4464);
        trigger = 1'b0;
`endif

        go_idle();
        tick(2);
        check("sb_drained", 32'(exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
